serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Serial pattern transmitter for the string-recognition datapath.
- Latches a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock, for a programmable number of repetitions.
- Serial output drives the single-bit input of the sequence detectors.
- Moore FSM with a start/busy/done handshake.

Parameters:
- WIDTH, 4: pattern length in bits (must be ≥2).
- REP_W, 4: width of the repetition-count input.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- start  input  1  request transmission; sampled only in IDLE.
- pattern_in  input  WIDTH  pattern to send, MSB first.
- rep_in  input  REP_W  number of pattern repetitions; 0 is treated as 1.
- seq_out  output  1  serial bit stream.
- bit_valid  output  1  high while seq_out carries a pattern (or parity) bit.
- busy  output  1  high from the cycle after start is accepted through the last bit.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports named clock and reset).
- Reset values: state=IDLE; shift register, pattern copy, bit counter and rep counter = 0; seq_out=0, bit_valid=0, busy=0, done=0.
- Outputs are Moore outputs, decoded from state and registers only.
  - seq_out = shreg[WIDTH-1] in SHIFT, 0 in every other state.
  - bit_valid = (SHIFT or PARITY); busy = same; done = (state==DONE).
- States and transitions:
  - IDLE: on posedge with start=1:
    - shreg <= pattern_in; pat_q <= pattern_in.
    - reps_left <= (rep_in==0 ? 1 : rep_in).
    - bit_cnt <= WIDTH-1.
    - go to SHIFT.
    - Otherwise stay in IDLE.
  - SHIFT: each clock:
    - shreg <= shreg << 1; bit_cnt decrements.
    - When bit_cnt==0 (last bit of the word):
      - if reps_left>1: reps_left--, shreg <= pat_q, bit_cnt <= WIDTH-1, stay in SHIFT.
      - else go to DONE.
    - Repetitions are back-to-back, with no idle gap between words.
  - DONE: one cycle, then IDLE unconditionally.
- Latency:
  - First bit appears on seq_out in the cycle after the edge that samples start.
  - Total valid bits = WIDTH*reps.
  - done is asserted the cycle after the last bit.
- Boundary conditions:
  - start is ignored in SHIFT, DONE and PARITY (no queuing). pattern_in and rep_in changes while busy have no effect.
  - start held high continuously: new transfer accepted in the IDLE cycle after DONE. Minimum gap between transfers is 2 cycles (DONE and IDLE).
  - rep_in = max (2^REP_W-1): the counter must not wrap; exactly that many words are sent.
  - Reset mid-transfer: outputs go to 0 immediately (asynchronously). No done pulse is issued. The next transfer needs a fresh start.
- Width rules: bit_cnt is clog2(WIDTH) bits; reps_left is REP_W bits.

Optional Feature:
- Macro: SERIAL_PATTERN_GEN_PARITY_EN
- Defined:
  - Adds a PARITY state after each word's last bit; seq_out = ^pat_q (even parity), bit_valid=1.
  - From PARITY: reload and return to SHIFT if reps_left>1, else go to DONE.
  - Valid bits = (WIDTH+1)*reps.
- Undefined: no PARITY state, no parity logic; behaviour exactly as above.

Test Plan:
- Reset released; pattern_in=4'b1101, rep_in=1, 1-cycle start pulse.
  - -> seq_out 1,1,0,1 on cycles 1–4 after start, bit_valid/busy high on those cycles.
  - -> done=1 on cycle 5, all outputs 0 on cycle 6.
- pattern_in=4'b1101, rep_in=3.
  - -> 12 consecutive valid bits 110111011101, no gaps.
  - -> done on cycle 13.
- rep_in=0, pattern_in=4'b1010.
  - -> exactly one word 1,0,1,0, then done.
- Start pulsed again at cycle 2 of an active transfer, with pattern_in changed to 4'b0000.
  - -> stream unchanged (1101), single done pulse.
- Reset asserted asynchronously mid-cycle at bit 3 of rep 2 of 3.
  - -> seq_out, bit_valid, busy go 0 before the next edge; no done.
  - -> a new start after release sends the full new pattern.
- With SERIAL_PATTERN_GEN_PARITY_EN, pattern 4'b1101, rep_in=2.
  - -> 1101 1 1101 1 (10 valid bits), done on cycle 11.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen: serial pattern transmitter for the string-recognition datapath.
//
// Latches a WIDTH-bit pattern on start and shifts it out MSB-first, one bit per clock,
// for a programmable number of back-to-back repetitions (rep_in == 0 behaves as 1).
// It is a Moore FSM with a start/busy/done handshake.
//
// Optional build macro: SERIAL_PATTERN_GEN_PARITY_EN
//   When defined, an even-parity bit (^pattern) follows every word.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   asynchronous, active-high; forces IDLE and clears all outputs
//   start       in   transmission request, sampled only in IDLE
//   pattern_in  in   [WIDTH-1:0] pattern to send, MSB first
//   rep_in      in   [REP_W-1:0] number of repetitions (0 treated as 1)
//   seq_out     out  serial bit stream
//   bit_valid   out  seq_out carries a pattern (or parity) bit
//   busy        out  transfer in progress (same timing as bit_valid)
//   done        out  one-cycle pulse after the final bit
module serial_pattern_gen #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [REP_W-1:0] rep_in,
    output logic             seq_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StParity, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic             seq_q, seq_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // Next-state logic; outputs are then decoded from the next state so they can be
    // registered and still line up with the state they describe.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        reps_d  = reps_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d = pattern_in;
                    pat_d   = pattern_in;
                    reps_d  = (rep_in == '0) ? REP_W'(1) : rep_in;
                    cnt_d   = LastCnt;
                    state_d = StShift;
                end
            end
            StShift: begin
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                    state_d = StParity;
`else
                    if (reps_q > REP_W'(1)) begin
                        // Reload for the next word with no idle gap.
                        reps_d  = reps_q - REP_W'(1);
                        shreg_d = pat_q;
                        cnt_d   = LastCnt;
                    end else begin
                        state_d = StDone;
                    end
`endif
                end
            end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            StParity: begin
                if (reps_q > REP_W'(1)) begin
                    reps_d  = reps_q - REP_W'(1);
                    shreg_d = pat_q;
                    cnt_d   = LastCnt;
                    state_d = StShift;
                end else begin
                    state_d = StDone;
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        seq_d   = 1'b0;
        valid_d = 1'b0;
        if (state_d == StShift) begin
            seq_d   = shreg_d[WIDTH-1];
            valid_d = 1'b1;
        end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        if (state_d == StParity) begin
            seq_d   = ^pat_d;
            valid_d = 1'b1;
        end
`endif
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            reps_q  <= '0;
            seq_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            reps_q  <= reps_d;
            seq_q   <= seq_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign seq_out   = seq_q;
    assign bit_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
module tb_serial_pattern_gen;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    localparam int Bits = 5;
`else
    localparam int Bits = 4;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pattern_in = 4'h0;
    logic [3:0] rep_in = 4'h0;
    logic       seq_out, bit_valid, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic [3:0] pat;
        logic [3:0] rep;
        logic [3:0] exp;  // {seq_out, bit_valid, busy, done}
    } vec_t;

    vec_t vecs[$];

    serial_pattern_gen #(.WIDTH(4), .REP_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .rep_in     (rep_in),
        .seq_out    (seq_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check_out(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {seq_out, bit_valid, busy, done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {seq,valid,busy,done}=%b expected %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Apply inputs, let one rising edge sample them, then settle 1 time unit.
    task automatic drive(input logic s, input logic [3:0] p, input logic [3:0] r);
        start      = s;
        pattern_in = p;
        rep_in     = r;
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic s, input logic [3:0] p, input logic [3:0] r,
                        input logic sq, input logic v, input logic d);
        vec_t e;
        e.start = s;
        e.pat   = p;
        e.rep   = r;
        e.exp   = {sq, v, v, d};
        vecs.push_back(e);
    endtask

    task automatic word(input logic s, input logic [3:0] p, input logic [3:0] r,
                        input logic [3:0] bits);
        // One word sent MSB first; start only on the first row.
        push(s, p, r, bits[3], 1'b1, 1'b0);
        push(1'b0, p, r, bits[2], 1'b1, 1'b0);
        push(1'b0, p, r, bits[1], 1'b1, 1'b0);
        push(1'b0, p, r, bits[0], 1'b1, 1'b0);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        push(1'b0, p, r, ^bits, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        int n_valid;
        int n_ones;
        bit seen_done;
        logic [3:0] pat;
        logic exp_bit;

        // Single word 1101, rep 1: bits, done, idle.
        word(1'b1, 4'b1101, 4'd1, 4'b1101);
        push(1'b0, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b1);
        push(1'b0, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b0);
        // rep_in = 0 sends exactly one word.
        word(1'b1, 4'b1010, 4'd0, 4'b1010);
        push(1'b0, 4'b1010, 4'd0, 1'b0, 1'b0, 1'b1);
        push(1'b0, 4'b1010, 4'd0, 1'b0, 1'b0, 1'b0);
        // Second start with changed pattern while busy is ignored.
        push(1'b1, 4'b1101, 4'd1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 4'b0000, 4'd5, 1'b1, 1'b1, 1'b0);
        push(1'b0, 4'b0000, 4'd5, 1'b0, 1'b1, 1'b0);
        push(1'b0, 4'b0000, 4'd5, 1'b1, 1'b1, 1'b0);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        push(1'b0, 4'b0000, 4'd5, 1'b1, 1'b1, 1'b0);
`endif
        push(1'b0, 4'b0000, 4'd5, 1'b0, 1'b0, 1'b1);
        push(1'b0, 4'b0000, 4'd5, 1'b0, 1'b0, 1'b0);
        // start held high: one IDLE cycle after DONE, then the next transfer.
        word(1'b1, 4'b1101, 4'd1, 4'b1101);
        push(1'b1, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b1);
        push(1'b1, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b0);
        word(1'b1, 4'b1101, 4'd1, 4'b1101);
        push(1'b0, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b1);
        push(1'b0, 4'b1101, 4'd1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check_out("reset_state", 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 4'h0, 4'h0);
        check_out("idle_after_reset", 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].pat, vecs[i].rep);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
        end

        // rep_in = 3: back-to-back words, done right after the last bit.
        pat = 4'b1101;
        drive(1'b1, pat, 4'd3);
        for (int i = 0; i < 3 * Bits; i++) begin
            if (i > 0) drive(1'b0, 4'h0, 4'h0);
            exp_bit = ((i % Bits) == 4) ? ^pat : pat[3 - (i % Bits)];
            check_out($sformatf("rep3_bit%0d", i), {exp_bit, 1'b1, 1'b1, 1'b0});
        end
        drive(1'b0, 4'h0, 4'h0);
        check_out("rep3_done", 4'b0001);
        drive(1'b0, 4'h0, 4'h0);
        check_out("rep3_idle", 4'b0000);

        // rep_in at maximum: counter must not wrap.
        n_valid = 0;
        n_ones = 0;
        seen_done = 1'b0;
        drive(1'b1, 4'b1001, 4'd15);
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (bit_valid) n_valid++;
            if (bit_valid && seq_out) n_ones++;
            if (done) seen_done = 1'b1;
            else drive(1'b0, 4'h0, 4'h0);
        end
        check_int("repmax_done_seen", int'(seen_done), 1);
        check_int("repmax_valid_bits", n_valid, 15 * Bits);
        check_int("repmax_one_bits", n_ones, 30);
        drive(1'b0, 4'h0, 4'h0);

        // Asynchronous reset at bit 3 of rep 2 of 3.
        drive(1'b1, 4'b1101, 4'd3);
        repeat (Bits + 2) drive(1'b0, 4'h0, 4'h0);
        check_out("pre_reset_bit", 4'b0110);
        #2 reset = 1'b1;
        #1;
        check_out("async_reset_outputs", 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'h0, 4'h0);
            check_out($sformatf("post_reset_quiet%0d", i), 4'b0000);
        end
        pat = 4'b0110;
        drive(1'b1, pat, 4'd1);
        for (int i = 0; i < Bits; i++) begin
            if (i > 0) drive(1'b0, 4'h0, 4'h0);
            exp_bit = (i == 4) ? ^pat : pat[3 - i];
            check_out($sformatf("post_reset_bit%0d", i), {exp_bit, 1'b1, 1'b1, 1'b0});
        end
        drive(1'b0, 4'h0, 4'h0);
        check_out("post_reset_done", 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
